// File: rtl/zynq_axis_packet_tx.sv
// AXI4-Stream packet transmitter: frames producer words into fixed-length packets behind a 2-entry registered FIFO.
// Optional statistics counters are built when ZYNQ_AXIS_PACKET_TX_STATS_EN is defined.
module zynq_axis_packet_tx #(
  parameter int data_width_p  = 32,
  parameter int len_width_p   = 16,
  parameter int keep_width_lp = data_width_p / 8,
  parameter int kbits_lp      = $clog2(keep_width_lp) + 1
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  input  logic                     start_i,
  input  logic [len_width_p-1:0]   len_i,
  input  logic [kbits_lp-1:0]      last_bytes_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic [data_width_p-1:0]  data_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  output logic                     tvalid_o,
  input  logic                     tready_i,
  output logic [data_width_p-1:0]  tdata_o,
  output logic [keep_width_lp-1:0] tkeep_o,
  output logic                     tlast_o,
  output logic [31:0]              pkt_count_o,
  output logic [31:0]              beat_count_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam logic [kbits_lp-1:0]    kfull_lp = kbits_lp'(keep_width_lp);
  localparam logic [len_width_p-1:0] one_lp   = len_width_p'(1);

  state_e                  state_r, state_n;
  logic [len_width_p-1:0]  rem_r, rem_n;
  logic [kbits_lp-1:0]     klast_r, klast_n;
  logic                    zero_done_r, zero_done_n;

  logic                     out_valid_r, sk_valid_r;
  logic [data_width_p-1:0]  out_data_r, sk_data_r;
  logic [keep_width_lp-1:0] out_keep_r, sk_keep_r;
  logic                     out_last_r, sk_last_r;

  logic                     ready_s, enq_s, deq_s, done_s;
  logic                     in_last_s;
  logic [keep_width_lp-1:0] in_keep_s;

  // LSB-aligned byte-enable mask covering nbytes bytes
  function automatic logic [keep_width_lp-1:0] keep_mask(input logic [kbits_lp-1:0] nbytes);
    logic [keep_width_lp-1:0] m;
    m = '0;
    for (int i = 0; i < keep_width_lp; i++) begin
      m[i] = (i < int'(nbytes));
    end
    return m;
  endfunction

  // Ready comes only from registered state, so it never sees tready_i
  assign ready_s   = (state_r == STREAM) && !sk_valid_r;
  assign enq_s     = v_i && ready_s;
  assign deq_s     = out_valid_r && tready_i;
  assign done_s    = (state_r == DRAIN) && deq_s && out_last_r;
  assign in_last_s = (rem_r == one_lp);
  assign in_keep_s = in_last_s ? keep_mask(klast_r) : {keep_width_lp{1'b1}};

  // FSM state and packet-control registers
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_r     <= IDLE;
      rem_r       <= '0;
      klast_r     <= '0;
      zero_done_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      rem_r       <= rem_n;
      klast_r     <= klast_n;
      zero_done_r <= zero_done_n;
    end
  end

  // Next-state decode
  always_comb begin
    state_n     = state_r;
    rem_n       = rem_r;
    klast_n     = klast_r;
    zero_done_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_n = STREAM;
            rem_n   = len_i;
            if ((last_bytes_i == '0) || (last_bytes_i > kfull_lp)) begin
              klast_n = kfull_lp;
            end else begin
              klast_n = last_bytes_i;
            end
          end else begin
            zero_done_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        if (enq_s) begin
          rem_n = rem_r - one_lp;
          if (in_last_s) begin
            state_n = DRAIN;
          end else begin
            state_n = STREAM;
          end
        end else begin
          state_n = STREAM;
        end
      end
      DRAIN: begin
        if (done_s) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output register plus skid entry; head only moves when empty or handshaking
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
      out_last_r  <= 1'b0;
      sk_valid_r  <= 1'b0;
      sk_data_r   <= '0;
      sk_keep_r   <= '0;
      sk_last_r   <= 1'b0;
    end else if (!out_valid_r || deq_s) begin
      if (sk_valid_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sk_data_r;
        out_keep_r  <= sk_keep_r;
        out_last_r  <= sk_last_r;
        sk_valid_r  <= 1'b0;
      end else if (enq_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= data_i;
        out_keep_r  <= in_keep_s;
        out_last_r  <= in_last_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (enq_s) begin
      sk_valid_r <= 1'b1;
      sk_data_r  <= data_i;
      sk_keep_r  <= in_keep_s;
      sk_last_r  <= in_last_s;
    end
  end

  assign busy_o      = (state_r != IDLE);
  assign done_o      = zero_done_r || done_s;
  assign ready_and_o = ready_s;
  assign tvalid_o    = out_valid_r;
  assign tdata_o     = out_data_r;
  assign tkeep_o     = out_keep_r;
  assign tlast_o     = out_last_r;

`ifdef ZYNQ_AXIS_PACKET_TX_STATS_EN
  logic [31:0] pkt_cnt_r, beat_cnt_r;

  // Beat and packet statistics, wrapping modulo 2^32
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      pkt_cnt_r  <= 32'd0;
      beat_cnt_r <= 32'd0;
    end else if (deq_s) begin
      beat_cnt_r <= beat_cnt_r + 32'd1;
      if (out_last_r) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
    end
  end

  assign pkt_count_o  = pkt_cnt_r;
  assign beat_count_o = beat_cnt_r;
`else
  assign pkt_count_o  = 32'd0;
  assign beat_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_zynq_axis_packet_tx.sv
// Directed scoreboard bench for zynq_axis_packet_tx (default 32-bit data, 16-bit length).
module tb_zynq_axis_packet_tx;

  logic        aclk_i = 1'b0;
  logic        aresetn_i;
  logic        start_i;
  logic [15:0] len_i;
  logic [2:0]  last_bytes_i;
  logic        busy_o, done_o;
  logic [31:0] data_i;
  logic        v_i, ready_and_o;
  logic        tvalid_o, tready_i;
  logic [31:0] tdata_o;
  logic [3:0]  tkeep_o;
  logic        tlast_o;
  logic [31:0] pkt_count_o, beat_count_o;

  always #5 aclk_i = ~aclk_i;

  zynq_axis_packet_tx dut (
    .aclk_i(aclk_i), .aresetn_i(aresetn_i), .start_i(start_i), .len_i(len_i),
    .last_bytes_i(last_bytes_i), .busy_o(busy_o), .done_o(done_o), .data_i(data_i),
    .v_i(v_i), .ready_and_o(ready_and_o), .tvalid_o(tvalid_o), .tready_i(tready_i),
    .tdata_o(tdata_o), .tkeep_o(tkeep_o), .tlast_o(tlast_o),
    .pkt_count_o(pkt_count_o), .beat_count_o(beat_count_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          sent_idx = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          cur_len = 0;
  logic [2:0]  cur_lb = 3'd0;
  logic [31:0] base = 32'd0;
  bit          zpend = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_keep;
  logic        held_last;
  logic [31:0] exp_pkt = 32'd0;
  logic [31:0] exp_beat = 32'd0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_last_keep(logic [2:0] lb);
    case (lb)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Sampled at the falling edge: checks outputs, then updates the scoreboard
  task automatic monitor();
    beat_t e;
    logic  exp_done;
    check("tvalid", tvalid_o, (q.size() != 0));
    if (q.size() == 2) check("full_ready", ready_and_o, 1'b0);
    if (stall_prev) begin
      check("hold_data", tdata_o, held_data);
      check("hold_keep", tkeep_o, held_keep);
      check("hold_last", tlast_o, held_last);
    end
    check("pkt_count", pkt_count_o, exp_pkt);
    check("beat_count", beat_count_o, exp_beat);
    exp_done = zpend;
    zpend = start_i && !busy_o && (len_i == 16'd0);
    if (tvalid_o && tready_i) begin
      if (q.size() == 0) begin
        check("spurious_beat", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        check("tdata", tdata_o, e.data);
        check("tkeep", tkeep_o, e.keep);
        check("tlast", tlast_o, e.last);
        beats++;
        if (e.last) exp_done = 1'b1;
`ifdef ZYNQ_AXIS_PACKET_TX_STATS_EN
        exp_beat = exp_beat + 32'd1;
        if (e.last) exp_pkt = exp_pkt + 32'd1;
`endif
      end
    end
    check("done", done_o, exp_done);
    if (done_o) done_cnt++;
    if (v_i && ready_and_o) begin
      e.data = data_i;
      e.last = (sent_idx + 1 == cur_len);
      e.keep = e.last ? exp_last_keep(cur_lb) : 4'b1111;
      q.push_back(e);
      sent_idx++;
    end
    stall_prev = tvalid_o && !tready_i;
    held_data  = tdata_o;
    held_keep  = tkeep_o;
    held_last  = tlast_o;
  endtask

  task automatic tick();
    @(negedge aclk_i);
    monitor();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic run_pkt(int len, logic [2:0] lb, logic [31:0] b, bit vrand, bit rtog, bit mid_start);
    int d0, bt0;
    bit got;
    d0 = done_cnt; bt0 = beats;
    cur_len = len; cur_lb = lb; base = b; sent_idx = 0;
    start_i = 1'b1; len_i = 16'(len); last_bytes_i = lb; v_i = 1'b0; data_i = b;
    tick();
    start_i = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      v_i      = (sent_idx < len) && (vrand ? ($urandom_range(0, 1) == 1) : 1'b1);
      tready_i = rtog ? (c % 2 == 0) : 1'b1;
      data_i   = base + 32'(sent_idx);
      start_i  = mid_start && (c == 2);
      len_i    = start_i ? 16'd2 : 16'(len);
      tick();
      got = (done_cnt != d0);
    end
    v_i = 1'b0; start_i = 1'b0; tready_i = 1'b1;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("beat_total", 32'(beats - bt0), 32'(len));
    check("idle_after", busy_o, 1'b0);
    check("fifo_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int d0, bt0;
    aresetn_i = 1'b0; start_i = 1'b0; len_i = 16'd0; last_bytes_i = 3'd0;
    data_i = 32'd0; v_i = 1'b0; tready_i = 1'b1;
    #12;
    check("rst_tvalid", tvalid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", ready_and_o, 1'b0);
    check("rst_tdata", tdata_o, 32'd0);
    check("rst_tkeep", tkeep_o, 4'd0);
    check("rst_tlast", tlast_o, 1'b0);
    check("rst_pkt", pkt_count_o, 32'd0);
    check("rst_beat", beat_count_o, 32'd0);
    @(posedge aclk_i); #2 aresetn_i = 1'b1;
    tick();

    run_pkt(4, 3'd4, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
    run_pkt(3, 3'd1, 32'h0000_000A, 1'b0, 1'b0, 1'b0);
    run_pkt(8, 3'd2, 32'h2000_0000, 1'b1, 1'b1, 1'b0);
    run_pkt(6, 3'd3, 32'h3000_0000, 1'b0, 1'b0, 1'b1);

    // zero-length packet: done only, no beats
    d0 = done_cnt; bt0 = beats;
    start_i = 1'b1; len_i = 16'd0; last_bytes_i = 3'd2;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("zero_done", 32'(done_cnt - d0), 32'd1);
    check("zero_beats", 32'(beats - bt0), 32'd0);

    // reset in the middle of a 5-beat packet
    bt0 = beats; cur_len = 5; cur_lb = 3'd4; base = 32'h4000_0000; sent_idx = 0;
    start_i = 1'b1; len_i = 16'd5; last_bytes_i = 3'd4; tready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 50 && (beats - bt0) < 2; c++) begin
      v_i = (sent_idx < 5);
      data_i = base + 32'(sent_idx);
      tick();
    end
    check("rst_point", 32'(beats - bt0), 32'd2);
    #1 aresetn_i = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_done", done_o, 1'b0);
    q.delete(); zpend = 1'b0; stall_prev = 1'b0; v_i = 1'b0;
    exp_pkt = 32'd0; exp_beat = 32'd0;
    repeat (2) tick();
    #3 aresetn_i = 1'b1;
    tick();
    run_pkt(2, 3'd3, 32'h5000_0000, 1'b0, 1'b0, 1'b0);

    run_pkt(1, 3'd0, 32'h6000_0000, 1'b0, 1'b0, 1'b0);
    run_pkt(1, 3'd7, 32'h7000_0000, 1'b0, 1'b1, 1'b0);
    run_pkt(5, 3'd2, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
